// File: rtl/icmp_pkg.sv
// Shared ICMP constants, IP user-sideband field positions and the echo-reply FSM states.
// Also holds the fixed payload pattern generator used by both checksum and transmit paths.
package icmp_pkg;

  localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;
  localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'd8;
  localparam logic [7:0] IP_PROTO_ICMP        = 8'd1;

  localparam int unsigned USER_LEN_MSB  = 55;
  localparam int unsigned USER_LEN_LSB  = 40;
  localparam int unsigned USER_FLAG_MSB = 39;
  localparam int unsigned USER_FLAG_LSB = 37;
  localparam int unsigned USER_TYPE_MSB = 36;
  localparam int unsigned USER_TYPE_LSB = 29;
  localparam int unsigned USER_OFF_MSB  = 28;
  localparam int unsigned USER_OFF_LSB  = 16;
  localparam int unsigned USER_ID_MSB   = 15;
  localparam int unsigned USER_ID_LSB   = 0;

  typedef enum logic [1:0] {IDLE, CALC, FOLD, SEND} icmp_state_e;

  // Payload byte k carries k[7:0]; word j holds bytes 8j..8j+7, first byte in the MSBs.
  function automatic logic [63:0] payload_word(input int unsigned j);
    logic [63:0] w;
    w = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      w[63-8*b -: 8] = 8'((8*j + b) & 32'hFF);
    end
    return w;
  endfunction

endpackage

// File: rtl/icmp_csum_acc.sv
// 32-bit ones-complement checksum accumulator: load, add four 16-bit halfwords per cycle,
// then fold the carries back in and invert into a registered 16-bit checksum.
module icmp_csum_acc (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_add,
  input  logic [63:0] i_word,
  input  logic        i_fold,
  output logic [15:0] o_csum
);

  logic [31:0] r_acc;
  logic [15:0] r_csum;
  logic [31:0] w_sum4;
  logic [16:0] w_s1;
  logic [15:0] w_s2;

  always_comb begin
    w_sum4 = 32'(i_word[63:48]) + 32'(i_word[47:32]) + 32'(i_word[31:16]) + 32'(i_word[15:0]);
    w_s1   = 17'(r_acc[15:0]) + 17'(r_acc[31:16]);
    w_s2   = w_s1[15:0] + 16'(w_s1[16]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_csum <= '0;
    end else begin
      if (i_load) begin
        r_acc <= i_load_val;
      end else if (i_add) begin
        r_acc <= r_acc + w_sum4;
      end
      if (i_fold) begin
        r_csum <= ~w_s2;
      end
    end
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/icmp_echo_tx.sv
// ICMP Echo Reply transmitter: captures ID/Seq from the receiver, checksums the fixed
// payload, then streams header plus payload as 64-bit AXI-Stream beats to the IP TX layer.
module icmp_echo_tx
  import icmp_pkg::*;
#(
  parameter int unsigned PAYLOAD_WORDS = 4,
  parameter logic [2:0]  IP_FLAGS      = 3'b000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_Identifier,
  input  logic [15:0] i_Sequence,
  input  logic        i_trigger,
  output logic [63:0] m_axis_ip_data,
  output logic [55:0] m_axis_ip_user,
  output logic [7:0]  m_axis_ip_keep,
  output logic        m_axis_ip_last,
  output logic        m_axis_ip_valid,
  input  logic        m_axis_ip_ready,
  output logic        o_busy
);

  localparam int unsigned IW       = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_WORDS - 1);
  localparam logic [15:0] ICMP_LEN = 16'(8 + 8*PAYLOAD_WORDS);

  icmp_state_e r_state, w_state_nxt;

  logic          r_pend;
  logic [15:0]   r_slot_id, r_slot_seq;
  logic [15:0]   r_id, r_seq, r_pkt_id;
  logic [IW-1:0] r_idx;
  logic [63:0]   r_data;
  logic [55:0]   r_user;
  logic [7:0]    r_keep;
  logic          r_last, r_valid;

  logic          w_load, w_add, w_fold, w_xfer;
  logic [15:0]   w_csum;
  logic [63:0]   w_word;
  logic [55:0]   w_user;

  assign w_xfer = r_valid && m_axis_ip_ready;
  assign w_word = payload_word(32'(r_idx));

  icmp_csum_acc u_csum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (32'(r_slot_id) + 32'(r_slot_seq)),
    .i_add      (w_add),
    .i_word     (w_word),
    .i_fold     (w_fold),
    .o_csum     (w_csum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_add       = 1'b0;
    w_fold      = 1'b0;
    unique case (r_state)
      IDLE: if (r_pend) begin
        w_load      = 1'b1;
        w_state_nxt = CALC;
      end
      CALC: begin
        w_add = 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = FOLD;
      end
      FOLD: begin
        w_fold      = 1'b1;
        w_state_nxt = SEND;
      end
      SEND: if (w_xfer && r_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_user = '0;
    w_user[USER_LEN_MSB:USER_LEN_LSB]   = ICMP_LEN;
    w_user[USER_FLAG_MSB:USER_FLAG_LSB] = IP_FLAGS;
    w_user[USER_TYPE_MSB:USER_TYPE_LSB] = IP_PROTO_ICMP;
    w_user[USER_OFF_MSB:USER_OFF_LSB]   = '0;
    w_user[USER_ID_MSB:USER_ID_LSB]     = r_pkt_id;
  end

  // A trigger in the same cycle IDLE consumes the slot wins, so it re-arms pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= 1'b0;
      r_slot_id  <= '0;
      r_slot_seq <= '0;
    end else if (i_trigger) begin
      r_pend     <= 1'b1;
      r_slot_id  <= i_Identifier;
      r_slot_seq <= i_Sequence;
    end else if (w_load) begin
      r_pend     <= 1'b0;
    end
  end

  // r_idx walks payload words in CALC, then is reused as the next payload beat in SEND.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_id     <= '0;
      r_seq    <= '0;
      r_idx    <= '0;
      r_pkt_id <= '0;
      r_data   <= '0;
      r_user   <= '0;
      r_keep   <= '0;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_load) begin
        r_id  <= r_slot_id;
        r_seq <= r_slot_seq;
        r_idx <= '0;
      end
      if (r_state == CALC) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (r_state == SEND) begin
        if (!r_valid) begin
          r_valid <= 1'b1;
          r_data  <= {ICMP_TYPE_ECHO_REPLY, 8'h00, w_csum, r_id, r_seq};
          r_user  <= w_user;
          r_keep  <= '1;
          r_last  <= 1'b0;
          r_idx   <= '0;
        end else if (w_xfer) begin
          if (r_last) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_data   <= '0;
            r_user   <= '0;
            r_keep   <= '0;
            r_pkt_id <= r_pkt_id + 1'b1;
          end else begin
            r_data <= w_word;
            r_last <= (r_idx == LAST_IDX);
            r_idx  <= r_idx + 1'b1;
          end
        end
      end
    end
  end

  assign m_axis_ip_data  = r_data;
  assign m_axis_ip_user  = r_user;
  assign m_axis_ip_keep  = r_keep;
  assign m_axis_ip_last  = r_last;
  assign m_axis_ip_valid = r_valid;
  assign o_busy          = (r_state != IDLE) || r_pend;

endmodule
